maindec: RTL and testbench

- Main control FSM of the multi-cycle MIPS controller.
- Sequences each instruction through fetch, decode, execute, memory and writeback states from the 6-bit opcode.
- Drives datapath enables and mux selects, and supplies the 2-bit aluop consumed by aludec, which is directly downstream.
- Sits in the controller beside aludec; together they feed the datapath.

---
 rtl/maindec_pkg.sv | 55 +++++
 rtl/maindec_ctrl.sv | 76 +++++++
 rtl/maindec.sv | 93 +++++++++
 tb/tb_maindec.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/maindec_pkg.sv
// Shared declarations for the multi-cycle MIPS controller: opcodes, main FSM
// states, the bundled control word and the aluop codes handed to aludec.
// Optional build macro: MAINDEC_BNE_EN adds the bne instruction and its BNEEX state.
package mips_decls_p;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101,
        OP_ADDI  = 6'b001000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_t;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
`ifdef MAINDEC_BNE_EN
        BNEEX   = 4'd12,
`endif
        JEX     = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Every datapath control produced by the main decoder except illegal.
    typedef struct packed {
        logic       pcwrite;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic       branch;
        logic       bne;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/maindec_ctrl.sv
// Moore output decoder of the main FSM: maps each state to its control word.
// Optional build macro: MAINDEC_BNE_EN enables the BNEEX decode.
module maindec_ctrl
    import mips_decls_p::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Per-state control word; anything not named stays 0, including unused encodings.
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
                ctrl.alusrcb = 2'b01;
                ctrl.aluop   = ALUOP_ADD;
            end
            DECODE: begin
                ctrl.alusrcb = 2'b11;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            MEMRD: begin
                ctrl.iord = 1'b1;
            end
            MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.branch  = 1'b1;
                ctrl.pcsrc   = 2'b01;
            end
            ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
            JEX: begin
                ctrl.pcwrite = 1'b1;
                ctrl.pcsrc   = 2'b10;
            end
`ifdef MAINDEC_BNE_EN
            BNEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.bne     = 1'b1;
                ctrl.pcsrc   = 2'b01;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/maindec.sv
// Main control FSM of the multi-cycle MIPS controller. Holds the state
// register, next-state logic, reset gating of write enables and the
// illegal-opcode flag; the per-state outputs come from maindec_ctrl.
// Optional build macro: MAINDEC_BNE_EN adds op 000101 (bne) via BNEEX.
module maindec
    import mips_decls_p::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       pcwrite,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       branch,
    output logic       bne,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl;
    logic   illegal_next;

    // State register; reset (active low) returns to FETCH without waiting for clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state; op matters only in DECODE and MEMADR.
    always_comb begin
        state_next   = FETCH;
        illegal_next = 1'b0;
        case (state_reg)
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = RTYPEEX;
                    OP_BEQ:       state_next = BEQEX;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JEX;
`ifdef MAINDEC_BNE_EN
                    OP_BNE:       state_next = BNEEX;
`endif
                    default: begin
                        state_next   = FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_next = MEMWB;
            RTYPEEX: state_next = RTYPEWB;
            ADDIEX:  state_next = ADDIWB;
            default: state_next = FETCH;
        endcase
    end

    maindec_ctrl u_ctrl (
        .state (state_reg),
        .ctrl  (ctrl)
    );

    // Write enables are suppressed for as long as reset is held low, so a
    // reset arriving mid-instruction cannot let a stray write through.
    assign pcwrite  = ctrl.pcwrite  & reset;
    assign memwrite = ctrl.memwrite & reset;
    assign irwrite  = ctrl.irwrite  & reset;
    assign regwrite = ctrl.regwrite & reset;
    assign branch   = ctrl.branch   & reset;
    assign bne      = ctrl.bne      & reset;
    assign alusrca  = ctrl.alusrca;
    assign iord     = ctrl.iord;
    assign memtoreg = ctrl.memtoreg;
    assign regdst   = ctrl.regdst;
    assign alusrcb  = ctrl.alusrcb;
    assign pcsrc    = ctrl.pcsrc;
    assign aluop    = ctrl.aluop;
    assign illegal  = illegal_next;

endmodule

// File: tb/tb_maindec.sv
// Scoreboard bench for maindec: stimulus pushes one hand-written expected
// control word per cycle, a monitor pops and compares on the falling edge.
module tb_maindec;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'b000000;
    logic       pcwrite, memwrite, irwrite, regwrite, alusrca, branch, bne;
    logic       iord, memtoreg, regdst, illegal;
    logic [1:0] alusrcb, pcsrc, aluop;

    always #5 clk = ~clk;

    maindec dut (
        .clk(clk), .reset(reset), .op(op),
        .pcwrite(pcwrite), .memwrite(memwrite), .irwrite(irwrite),
        .regwrite(regwrite), .alusrca(alusrca), .branch(branch), .bne(bne),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal)
    );

    // Field order: pcwrite memwrite irwrite regwrite alusrca branch bne iord
    //              memtoreg regdst _ alusrcb _ pcsrc _ aluop _ illegal
    localparam logic [16:0] W_FETCH   = 17'b1_0_1_0_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] W_RSTF    = 17'b0_0_0_0_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] W_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] W_DECILL  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] W_MEMADR  = 17'b0_0_0_0_1_0_0_0_0_0_10_00_00_0;
    localparam logic [16:0] W_MEMRD   = 17'b0_0_0_0_0_0_0_1_0_0_00_00_00_0;
    localparam logic [16:0] W_MEMWB   = 17'b0_0_0_1_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] W_MEMWR   = 17'b0_1_0_0_0_0_0_1_0_0_00_00_00_0;
    localparam logic [16:0] W_RTYPEEX = 17'b0_0_0_0_1_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] W_RTYPEWB = 17'b0_0_0_1_0_0_0_0_0_1_00_00_00_0;
    localparam logic [16:0] W_BEQEX   = 17'b0_0_0_0_1_1_0_0_0_0_00_01_01_0;
    localparam logic [16:0] W_ADDIEX  = 17'b0_0_0_0_1_0_0_0_0_0_10_00_00_0;
    localparam logic [16:0] W_ADDIWB  = 17'b0_0_0_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] W_JEX     = 17'b1_0_0_0_0_0_0_0_0_0_00_10_00_0;
    localparam logic [16:0] W_BNEEX   = 17'b0_0_0_0_1_0_1_0_0_0_00_01_01_0;

    typedef struct {
        string       name;
        logic [16:0] word;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Drive one cycle's inputs just after the rising edge and queue what that cycle must show.
    task automatic step(input logic r, input logic [5:0] o, input string nm, input logic [16:0] w);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r;
        op    = o;
        e.name = nm;
        e.word = w;
        q.push_back(e);
    endtask

    // Monitor: compare the full output word against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [16:0] got;
            e   = q.pop_front();
            got = {pcwrite, memwrite, irwrite, regwrite, alusrca, branch, bne,
                   iord, memtoreg, regdst, alusrcb, pcsrc, aluop, illegal};
            n_vec++;
            if (got !== e.word) begin
                n_miss++;
                $display("FAIL %s: got %b required %b", e.name, got, e.word);
            end else begin
                $display("vec %0d %s: %b ok", n_vec, e.name, got);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d vectors pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held low for three cycles: FETCH with writes gated.
        step(1'b0, 6'b111111, "rst0", W_RSTF);
        step(1'b0, 6'b111111, "rst1", W_RSTF);
        step(1'b0, 6'b111111, "rst2", W_RSTF);
        step(1'b1, 6'b111111, "fetch_after_rel", W_FETCH);
        // LW: 5 states
        step(1'b1, 6'b100011, "lw_decode", W_DECODE);
        step(1'b1, 6'b100011, "lw_memadr", W_MEMADR);
        step(1'b1, 6'b000000, "lw_memrd", W_MEMRD);
        step(1'b1, 6'b101011, "lw_memwb", W_MEMWB);
        step(1'b1, 6'b111111, "fetch", W_FETCH);
        // R-type; op change during RTYPEEX has no effect
        step(1'b1, 6'b000000, "r_decode", W_DECODE);
        step(1'b1, 6'b100011, "r_ex", W_RTYPEEX);
        step(1'b1, 6'b100011, "r_wb", W_RTYPEWB);
        step(1'b1, 6'b000000, "fetch", W_FETCH);
        // BEQ
        step(1'b1, 6'b000100, "beq_decode", W_DECODE);
        step(1'b1, 6'b000100, "beq_ex", W_BEQEX);
        step(1'b1, 6'b000000, "fetch", W_FETCH);
        // ADDI
        step(1'b1, 6'b001000, "addi_decode", W_DECODE);
        step(1'b1, 6'b001000, "addi_ex", W_ADDIEX);
        step(1'b1, 6'b001000, "addi_wb", W_ADDIWB);
        step(1'b1, 6'b000000, "fetch", W_FETCH);
        // J
        step(1'b1, 6'b000010, "j_decode", W_DECODE);
        step(1'b1, 6'b000010, "j_ex", W_JEX);
        step(1'b1, 6'b000000, "fetch", W_FETCH);
        // Illegal opcode: flag only in DECODE, then straight back to FETCH
        step(1'b1, 6'b111111, "ill_decode", W_DECILL);
        step(1'b1, 6'b111111, "ill_fetch", W_FETCH);
        // SW full sequence
        step(1'b1, 6'b101011, "sw_decode", W_DECODE);
        step(1'b1, 6'b101011, "sw_memadr", W_MEMADR);
        step(1'b1, 6'b101011, "sw_memwr", W_MEMWR);
        step(1'b1, 6'b000000, "fetch", W_FETCH);
        // SW with reset arriving in the MEMWR cycle
        step(1'b1, 6'b101011, "sw2_decode", W_DECODE);
        step(1'b1, 6'b101011, "sw2_memadr", W_MEMADR);
        step(1'b0, 6'b101011, "sw2_rst_in_memwr", W_RSTF);
        step(1'b0, 6'b101011, "sw2_rst_hold", W_RSTF);
        step(1'b1, 6'b000000, "restart_fetch", W_FETCH);
        step(1'b1, 6'b000000, "restart_decode", W_DECODE);
        step(1'b1, 6'b000000, "restart_rex", W_RTYPEEX);
        step(1'b1, 6'b000000, "restart_rwb", W_RTYPEWB);
        step(1'b1, 6'b000000, "fetch", W_FETCH);
        // op 000101: bne when enabled, illegal otherwise
`ifdef MAINDEC_BNE_EN
        step(1'b1, 6'b000101, "bne_decode", W_DECODE);
        step(1'b1, 6'b000101, "bne_ex", W_BNEEX);
        step(1'b1, 6'b000000, "fetch", W_FETCH);
`else
        step(1'b1, 6'b000101, "bne_decode_ill", W_DECILL);
        step(1'b1, 6'b000000, "bne_fetch", W_FETCH);
`endif
        step(1'b1, 6'b000000, "final_decode", W_DECODE);
        // Let the monitor drain, bounded to a few cycles.
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d vectors left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
